// File: rtl/bbox_frame_scheduler_if.sv
// Producer, frame-sync and overlay handshake signals of the bbox ping-pong scheduler.
// The slave modport is the scheduler's view. The master modport is the view of the
// producer and overlay side.
interface bbox_frame_scheduler_if #(
    parameter int CW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_bbox;
    logic          frame_end;
    logic          vsync;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_bbox;
    logic [CW-1:0] out_idx;
    logic          out_last;
    logic          frame_done;
    logic [CW-1:0] committed_count;
    logic [15:0]   drop_count;

    modport slave (
        input  in_valid, in_bbox, frame_end, vsync, out_ready,
        output in_ready, out_valid, out_bbox, out_idx, out_last, frame_done,
               committed_count, drop_count
    );

    modport master (
        output in_valid, in_bbox, frame_end, vsync, out_ready,
        input  in_ready, out_valid, out_bbox, out_idx, out_last, frame_done,
               committed_count, drop_count
    );
endinterface

// File: rtl/bbox_frame_scheduler.sv
// Ping-pong bbox bank: commit one edge after frame_end (deferred while streaming),
// stream one edge after vsync. in_ready drops while a commit is pending; out_* hold on stall.
module bbox_frame_scheduler #(
    parameter int          MAX_BOXES = 10,
    parameter int          DECIM     = 3,
    parameter logic [63:0] EMPTY_BOX = 64'h1,
    parameter int          CW        = $clog2(MAX_BOXES + 1)
) (
    input logic                   clk,
    input logic                   rst_n,
    bbox_frame_scheduler_if.slave bus
);
    localparam int             DCW     = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DCW-1:0] DLAST   = DCW'(DECIM - 1);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_BOXES);

    typedef enum logic {R_IDLE, R_STREAM} rd_state_e;

    rd_state_e      state_q, state_d;
    logic [63:0]    bank_q [2][MAX_BOXES];
    logic           wsel_q, wsel_d;
    logic [CW-1:0]  wcount_q, wcount_d;
    logic [CW-1:0]  ridx_q, ridx_d;
    logic [CW-1:0]  ccount_q, ccount_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [15:0]    drop_q, drop_d;
    logic           commit_pend_q, commit_pend_d;
    logic           vsync_pend_q, vsync_pend_d;
    logic           frame_done_q, frame_done_d;

    logic accept, store, wr_en, commit_do, new_pend, vs_req, last;

    assign accept    = bus.in_valid && bus.in_ready;
    assign store     = accept && (dcnt_q == DLAST);
    assign wr_en     = store && (wcount_q != MAX_CNT);
    assign commit_do = commit_pend_q && (state_q == R_IDLE);
    assign new_pend  = bus.frame_end && !commit_pend_q;
    assign vs_req    = bus.vsync || vsync_pend_q;
    assign last      = (state_q == R_STREAM) && (ridx_q == ccount_q - CW'(1));

    always_comb begin
        state_d       = state_q;
        wsel_d        = wsel_q;
        wcount_d      = wcount_q;
        ridx_d        = ridx_q;
        ccount_d      = ccount_q;
        dcnt_d        = dcnt_q;
        drop_d        = drop_q;
        commit_pend_d = commit_pend_q;
        vsync_pend_d  = vsync_pend_q;
        frame_done_d  = 1'b0;

        if (accept) begin
            dcnt_d = (dcnt_q == DLAST) ? '0 : dcnt_q + DCW'(1);
        end
        if (wr_en) begin
            wcount_d = wcount_q + CW'(1);
        end
        if (store && !wr_en && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
        if (bus.frame_end) begin
            commit_pend_d = 1'b1;
        end
        if (commit_do) begin
            wsel_d        = ~wsel_q;
            ccount_d      = wcount_q;
            wcount_d      = '0;
            dcnt_d        = '0;
            commit_pend_d = 1'b0;
        end

        case (state_q)
            R_IDLE: begin
                if (vs_req) begin
                    // A swap in progress (or just requested) must finish before the
                    // stream reads the bank, so the vsync waits one more cycle.
                    if (commit_do || new_pend) begin
                        vsync_pend_d = 1'b1;
                    end else if (ccount_q != '0) begin
                        state_d      = R_STREAM;
                        ridx_d       = '0;
                        vsync_pend_d = 1'b0;
                    end else begin
                        frame_done_d = 1'b1;
                        vsync_pend_d = 1'b0;
                    end
                end
            end
            R_STREAM: begin
                if (bus.out_ready) begin
                    if (last) begin
                        state_d      = R_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        ridx_d = ridx_q + CW'(1);
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= R_IDLE;
            wsel_q        <= 1'b0;
            wcount_q      <= '0;
            ridx_q        <= '0;
            ccount_q      <= '0;
            dcnt_q        <= '0;
            drop_q        <= '0;
            commit_pend_q <= 1'b0;
            vsync_pend_q  <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wsel_q        <= wsel_d;
            wcount_q      <= wcount_d;
            ridx_q        <= ridx_d;
            ccount_q      <= ccount_d;
            dcnt_q        <= dcnt_d;
            drop_q        <= drop_d;
            commit_pend_q <= commit_pend_d;
            vsync_pend_q  <= vsync_pend_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // Commit and write are exclusive: in_ready is low whenever commit_pend is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < MAX_BOXES; s++) begin
                    bank_q[b][s] <= EMPTY_BOX;
                end
            end
        end else if (commit_do) begin
            for (int s = 0; s < MAX_BOXES; s++) begin
                bank_q[!wsel_q][s] <= EMPTY_BOX;
            end
        end else if (wr_en) begin
            bank_q[wsel_q][wcount_q] <= bus.in_bbox;
        end
    end

    assign bus.in_ready        = !commit_pend_q;
    assign bus.out_valid       = (state_q == R_STREAM);
    assign bus.out_bbox        = (state_q == R_STREAM) ? bank_q[!wsel_q][ridx_q] : EMPTY_BOX;
    assign bus.out_idx         = (state_q == R_STREAM) ? ridx_q : '0;
    assign bus.out_last        = last;
    assign bus.frame_done      = frame_done_q;
    assign bus.committed_count = ccount_q;
    assign bus.drop_count      = drop_q;
endmodule
